// File: rtl/ofmap_pkg.sv
// rtl/ofmap_pkg.sv - shared widths, state encoding and the requantizer
// OFMAP_WRITER_RELU_EN selects ReLU with unsigned saturation; otherwise signed saturation.
package ofmap_pkg;

  localparam int PSUM_WIDTH = 20;
  localparam int DATA_WIDTH = 8;
  localparam int STREAM_W   = 4;
  localparam int ADDR_WIDTH = 16;
  localparam int WORD_WIDTH = DATA_WIDTH * STREAM_W;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

`ifdef OFMAP_WRITER_RELU_EN
  localparam logic signed [PSUM_WIDTH:0] SAT_HI = (PSUM_WIDTH+1)'(255);
  localparam logic signed [PSUM_WIDTH:0] SAT_LO = '0;
`else
  localparam logic signed [PSUM_WIDTH:0] SAT_HI = (PSUM_WIDTH+1)'(127);
  localparam logic signed [PSUM_WIDTH:0] SAT_LO = (PSUM_WIDTH+1)'(-128);
`endif

  // One extra bit of headroom keeps the rounding add from wrapping.
  function automatic logic [DATA_WIDTH-1:0] requant(input logic [PSUM_WIDTH-1:0] psum,
                                                    input logic [4:0]            shift);
    logic signed [PSUM_WIDTH:0] ext;
    logic signed [PSUM_WIDTH:0] rnd;
    logic signed [PSUM_WIDTH:0] r;
    ext = $signed({psum[PSUM_WIDTH-1], psum});
    rnd = (shift == 5'd0) ? '0 : $signed((PSUM_WIDTH+1)'(1) << (shift - 5'd1));
    r   = (ext + rnd) >>> shift;
    if (r > SAT_HI)
      return SAT_HI[DATA_WIDTH-1:0];
    else if (r < SAT_LO)
      return SAT_LO[DATA_WIDTH-1:0];
    else
      return r[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/ofmap_writer_if.sv
// rtl/ofmap_writer_if.sv - psum input stream and output-RAM write port
interface ofmap_writer_if;
  import ofmap_pkg::*;

  logic [PSUM_WIDTH-1:0] psum_in;
  logic                  psum_valid;
  logic                  wr_en;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WORD_WIDTH-1:0] wr_data;

  modport master (
    input  psum_in, psum_valid, wr_ready,
    output wr_en, wr_addr, wr_data
  );

  modport slave (
    output psum_in, psum_valid, wr_ready,
    input  wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/ofmap_word_fifo.sv
// rtl/ofmap_word_fifo.sv - synchronous FIFO for packed output words
module ofmap_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/ofmap_writer.sv
// rtl/ofmap_writer.sv - requantize psums, pack into words, buffer and write one output map
// Saturation mode follows OFMAP_WRITER_RELU_EN (resolved in ofmap_pkg::requant).
module ofmap_writer
  import ofmap_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4:0]            cfg_shift,
  input  logic [ADDR_WIDTH-1:0] cfg_o_dim,
  input  logic [ADDR_WIDTH-1:0] cfg_words_per_pix,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  ofmap_writer_if.master        bus,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);
  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_FLUSH = FLUSH;
  localparam logic [1:0] S_DONE  = DONE;
  localparam int CW  = 2 * ADDR_WIDTH;
  localparam int LW  = (STREAM_W > 1) ? $clog2(STREAM_W) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]            state;
  logic [4:0]            shift_q;
  logic [CW-1:0]         total_q;
  logic [CW-1:0]         word_cnt;
  logic [CW-1:0]         o_ext;
  logic [CW-1:0]         wpp_ext;
  logic [LW-1:0]         lane;
  logic [WORD_WIDTH-1:0] pack_buf;
  logic [WORD_WIDTH-1:0] pack_word;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  pack_push;
  logic                  last_word;
  logic                  drained;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [FCW-1:0]        fifo_count;
  logic [WORD_WIDTH-1:0] fifo_dout;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  overflow_q;

  assign o_ext   = CW'(cfg_o_dim);
  assign wpp_ext = CW'(cfg_words_per_pix);

  always_comb begin
    pack_word = pack_buf;
    pack_word[(STREAM_W-1-int'(lane))*DATA_WIDTH +: DATA_WIDTH] = s1_data;
  end

  assign pack_push = s1_valid && (state == S_RUN) && (lane == LW'(STREAM_W-1));
  assign last_word = pack_push && ((word_cnt + CW'(1)) == total_q);
  assign fifo_pop  = !fifo_empty && bus.wr_ready;
  // Done may fire in the cycle after the final pop rather than waiting to observe empty.
  assign drained   = fifo_empty || (fifo_pop && (fifo_count == FCW'(1)));

  ofmap_word_fifo #(
    .WIDTH(WORD_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (pack_push),
    .pop  (fifo_pop),
    .din  (pack_word),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      shift_q    <= '0;
      total_q    <= '0;
      word_cnt   <= '0;
      lane       <= '0;
      pack_buf   <= '0;
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      addr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      s1_valid <= bus.psum_valid && (state == S_RUN);
      s1_data  <= requant(bus.psum_in, shift_q);

      if (s1_valid && (state == S_RUN)) begin
        if (pack_push) begin
          lane     <= '0;
          pack_buf <= '0;
          word_cnt <= word_cnt + CW'(1);
          if (fifo_full && !fifo_pop)
            overflow_q <= 1'b1;
        end else begin
          lane     <= lane + LW'(1);
          pack_buf <= pack_word;
        end
      end

      if (fifo_pop)
        addr_q <= addr_q + ADDR_WIDTH'(1);

      case (state)
        S_IDLE: if (start) begin
          shift_q    <= cfg_shift;
          total_q    <= o_ext * o_ext * wpp_ext;
          word_cnt   <= '0;
          lane       <= '0;
          pack_buf   <= '0;
          addr_q     <= cfg_base;
          overflow_q <= 1'b0;
          state      <= S_RUN;
        end
        S_RUN: begin
          if (total_q == '0)
            state <= S_DONE;
          else if (last_word)
            state <= S_FLUSH;
        end
        S_FLUSH: if (drained) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.wr_en   = !fifo_empty;
  assign bus.wr_data = fifo_empty ? '0 : fifo_dout;
  assign bus.wr_addr = addr_q;
  assign busy        = (state == S_RUN) || (state == S_FLUSH);
  assign done        = (state == S_DONE);
  assign overflow    = overflow_q;
endmodule

// File: tb/tb_ofmap_writer.sv
// tb/tb_ofmap_writer.sv - scoreboard bench for ofmap_writer with an arithmetic reference model
module tb_ofmap_writer;
  import ofmap_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  cfg_shift = '0;
  logic [15:0] cfg_o_dim = '0;
  logic [15:0] cfg_wpp = '0;
  logic [15:0] cfg_base = '0;
  logic        busy;
  logic        done;
  logic        overflow;

  ofmap_writer_if bus();

  ofmap_writer #(.FIFO_DEPTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .cfg_shift        (cfg_shift),
    .cfg_o_dim        (cfg_o_dim),
    .cfg_words_per_pix(cfg_wpp),
    .cfg_base         (cfg_base),
    .bus              (bus),
    .busy             (busy),
    .done             (done),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   n_writes = 0;
  int   last_wr_cyc = 0;
  int   first_wr_cyc = -1;
  int   done_cyc = 0;
  int   last_psum_cyc = 0;
  bit   rand_ready = 1'b0;
  logic ready_force = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    bus.wr_ready = rand_ready ? ((cyc % 4 == 0) || ($urandom_range(0, 1) == 1)) : ready_force;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cyc = cyc;
    if (!rst && bus.wr_en && first_wr_cyc < 0) first_wr_cyc = cyc;
    if (!rst && bus.wr_en && bus.wr_ready) begin
      n_writes++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with empty scoreboard",
                 bus.wr_addr, bus.wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {48'd0, bus.wr_addr}, {48'd0, e.addr});
        chk("wr_data", {32'd0, bus.wr_data}, {32'd0, e.data});
      end
    end
  end

  // Round-half-up division by 2^sh using floor semantics, then clamp.
  function automatic logic [7:0] model_q(input int p, input int sh);
    int d, num, q;
    d   = 1 << sh;
    num = p + ((sh > 0) ? d / 2 : 0);
    q   = num / d;
    if ((num % d) != 0 && num < 0) q = q - 1;
`ifdef OFMAP_WRITER_RELU_EN
    if (q < 0) q = 0;
    if (q > 255) q = 255;
`else
    if (q > 127) q = 127;
    if (q < -128) q = -128;
`endif
    return 8'(q);
  endfunction

  function automatic int rand_psum();
    if ($urandom_range(0, 1) == 1)
      return int'($urandom_range(0, 4000)) - 2000;
    return int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int ps[$], input int sh, input logic [15:0] base, input int nkeep);
    for (int w = 0; w < ps.size() / 4 && w < nkeep; w++) begin
      wr_t e;
      logic [31:0] wd;
      wd = '0;
      for (int l = 0; l < 4; l++) wd = {wd[23:0], model_q(ps[4*w+l], sh)};
      e.addr = base + 16'(w);
      e.data = wd;
      exp_q.push_back(e);
    end
  endtask

  task automatic start_map(input int sh, input int o, input int wpp, input logic [15:0] base);
    cfg_shift = 5'(sh);
    cfg_o_dim = 16'(o);
    cfg_wpp   = 16'(wpp);
    cfg_base  = base;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    cfg_shift = 5'($urandom);
    cfg_o_dim = 16'($urandom);
    cfg_wpp   = 16'($urandom);
    cfg_base  = 16'($urandom);
  endtask

  task automatic send_psums(input int ps[$], input int gmax);
    foreach (ps[i]) begin
      bus.psum_valid = 1'b1;
      bus.psum_in    = 20'(ps[i]);
      last_psum_cyc  = cyc;
      tick();
      bus.psum_valid = 1'b0;
      bus.psum_in    = 20'($urandom);
      if (gmax > 0) repeat ($urandom_range(0, gmax)) tick();
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      @(negedge clk);
      chk({name, "_done_pulse"}, 64'(done), 64'd0);
      chk({name, "_busy_after"}, 64'(busy), 64'd0);
    end
    tick();
    chk({name, "_scoreboard_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int ps[$];
    int w0;
    bus.psum_valid = 1'b0;
    bus.psum_in    = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Sequential psums 1..16 into a 2x2 map at base 0x10
    ps.delete();
    for (int i = 1; i <= 16; i++) ps.push_back(i);
    push_words(ps, 0, 16'h0010, 4);
    w0 = n_writes;
    start_map(0, 2, 1, 16'h0010);
    @(negedge clk);
    chk("t1_busy", 64'(busy), 64'd1);
    send_psums(ps, 0);
    wait_done("t1", 200);
    chk("t1_writes", 64'(n_writes - w0), 64'd4);
    chk("t1_done_latency", 64'(done_cyc - last_wr_cyc), 64'd1);
    chk("t1_overflow", 64'(overflow), 64'd0);

    // Rounding and saturation, plus psum-to-write latency
    ps = '{24, 23, -40, 5000};
    push_words(ps, 4, 16'h0020, 1);
    start_map(4, 1, 1, 16'h0020);
    first_wr_cyc = -1;
    send_psums(ps, 0);
    wait_done("t2", 200);
    chk("t2_latency", 64'(first_wr_cyc - last_psum_cyc), 64'd2);

    // Backpressure: six words against a four-entry FIFO
    ready_force = 1'b0;
    ps.delete();
    for (int i = 0; i < 24; i++) ps.push_back(rand_psum());
    push_words(ps, 3, 16'h0040, 4);
    w0 = n_writes;
    start_map(3, 1, 6, 16'h0040);
    send_psums(ps, 0);
    repeat (16) tick();
    @(negedge clk);
    chk("t3_overflow_set", 64'(overflow), 64'd1);
    chk("t3_wr_en_held", 64'(bus.wr_en), 64'd1);
    chk("t3_busy", 64'(busy), 64'd1);
    chk("t3_no_writes_yet", 64'(n_writes - w0), 64'd0);
    tick();
    ready_force = 1'b1;
    wait_done("t3", 200);
    chk("t3_writes", 64'(n_writes - w0), 64'd4);
    chk("t3_overflow_sticky", 64'(overflow), 64'd1);

    // Push onto a full FIFO in the same cycle as a pop
    ready_force = 1'b0;
    ps.delete();
    for (int i = 0; i < 20; i++) ps.push_back(rand_psum());
    push_words(ps, 2, 16'h0080, 5);
    w0 = n_writes;
    start_map(2, 1, 5, 16'h0080);
    @(negedge clk);
    chk("t4_overflow_cleared_by_start", 64'(overflow), 64'd0);
    send_psums(ps[0:15], 0);
    repeat (3) tick();
    send_psums(ps[16:19], 0);
    ready_force = 1'b1;
    wait_done("t4", 200);
    chk("t4_writes", 64'(n_writes - w0), 64'd5);
    chk("t4_overflow", 64'(overflow), 64'd0);

    // Reset in the middle of a map with buffered and dropped words
    ready_force = 1'b0;
    ps.delete();
    for (int i = 0; i < 20; i++) ps.push_back(rand_psum());
    w0 = n_writes;
    start_map(1, 3, 1, 16'h0050);
    send_psums(ps, 0);
    repeat (2) tick();
    @(negedge clk);
    chk("t5_overflow_before_rst", 64'(overflow), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_wr_en_after_rst", 64'(bus.wr_en), 64'd0);
    chk("t5_busy_after_rst", 64'(busy), 64'd0);
    chk("t5_overflow_after_rst", 64'(overflow), 64'd0);
    tick();
    ready_force = 1'b1;
    ps.delete();
    for (int i = 0; i < 4; i++) ps.push_back(rand_psum());
    send_psums(ps, 0);
    repeat (3) tick();
    chk("t5_idle_psums_ignored", 64'(n_writes - w0), 64'd0);
    ps.delete();
    for (int i = 0; i < 4; i++) ps.push_back(rand_psum());
    push_words(ps, 0, 16'h0000, 1);
    start_map(0, 1, 1, 16'h0000);
    send_psums(ps, 1);
    wait_done("t5", 200);

    // Address wrap, with a start pulse while busy that must be ignored
    ps.delete();
    for (int i = 0; i < 8; i++) ps.push_back(rand_psum());
    push_words(ps, 5, 16'hFFFF, 2);
    w0 = n_writes;
    start_map(5, 1, 2, 16'hFFFF);
    send_psums(ps[0:3], 0);
    cfg_base  = 16'h1234;
    cfg_o_dim = 16'd5;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    send_psums(ps[4:7], 0);
    wait_done("t6", 200);
    chk("t6_writes", 64'(n_writes - w0), 64'd2);

    // Empty map
    w0 = n_writes;
    start_map(0, 0, 3, 16'h0100);
    wait_done("t7", 10);
    chk("t7_writes", 64'(n_writes - w0), 64'd0);

    // Randomized maps with random write backpressure
    rand_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      int o, wpp, sh;
      logic [15:0] base;
      o    = int'($urandom_range(1, 3));
      wpp  = int'($urandom_range(1, 2));
      sh   = int'($urandom_range(0, 19));
      base = 16'($urandom);
      ps.delete();
      for (int i = 0; i < 4 * o * o * wpp; i++) ps.push_back(rand_psum());
      push_words(ps, sh, base, o * o * wpp);
      w0 = n_writes;
      start_map(sh, o, wpp, base);
      send_psums(ps, 2);
      wait_done("rand", 400);
      chk("rand_writes", 64'(n_writes - w0), 64'(o * o * wpp));
      chk("rand_overflow", 64'(overflow), 64'd0);
    end
    rand_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
